// File: rtl/jk_counter_pkg.sv
// Shared types and JK/T excitation helpers for the JK-on-T up/down counter.
package jk_counter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_t;

    // T excitation that makes a T flip-flop behave as a JK flip-flop.
    function automatic logic jk_to_t(input logic j, input logic k, input logic q);
        return (j & ~q) | (k & q);
    endfunction

    // {J,K} that moves a cell from q to next without ever using the toggle code.
    function automatic jk_cmd_t jk_excite(input logic q, input logic next);
        return jk_cmd_t'({next & ~q, ~next & q});
    endfunction

endpackage

// File: rtl/jk_counter_t_core_cell.sv
// Single counter bit: a T flip-flop with a JK front end and a per-bit reset value.
module jk_t_cell
    import jk_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;
    logic w_t;

    assign w_t = jk_to_t(j, k, r_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= rst_val;
        end else begin
            r_q <= r_q ^ w_t;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/jk_counter_t_core.sv
// Up/down modulo counter built from JK-on-T cells; next state is decoded into per-bit J/K.
// Define COUNTER_SAT_EN to saturate at the range ends; wrap then flags a blocked count.
module jk_counter_t_core
    import jk_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (2 ** WIDTH) - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH + 1)'(MAX_COUNT);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_BITS = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH:0]   w_load_ext;
    logic             w_wrap_next;
    logic             r_wrap;

    // One extra bit so overflow past MAX_COUNT and borrow below 0 are both visible.
    assign w_inc      = {1'b0, w_q} + (WIDTH + 1)'(1);
    assign w_dec      = {1'b0, w_q} - (WIDTH + 1)'(1);
    assign w_load_ext = {1'b0, load_val};

    always_comb begin
        w_next      = w_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_next = (w_load_ext > MAX_EXT) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (w_inc > MAX_EXT) begin
`ifdef COUNTER_SAT_EN
                    w_next = w_q;
`else
                    w_next = '0;
`endif
                    w_wrap_next = 1'b1;
                end else begin
                    w_next = w_inc[WIDTH-1:0];
                end
            end else begin
                if (w_dec[WIDTH]) begin
`ifdef COUNTER_SAT_EN
                    w_next = w_q;
`else
                    w_next = MAX_VAL;
`endif
                    w_wrap_next = 1'b1;
                end else begin
                    w_next = w_dec[WIDTH-1:0];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic [1:0] w_jk;

            assign w_jk    = jk_excite(w_q[gi], w_next[gi]);
            assign w_j[gi] = w_jk[1];
            assign w_k[gi] = w_jk[0];

            jk_t_cell u_cell (
                .clk     (clk),
                .reset   (reset),
                .rst_val (RST_BITS[gi]),
                .j       (w_j[gi]),
                .k       (w_k[gi]),
                .q       (w_q[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = w_q;
    assign qbar = ~w_q;
    assign tc   = up_dn ? (w_q == MAX_VAL) : (w_q == '0);
    assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_counter_t_core.sv
// Scoreboard bench for jk_counter_t_core: a full-range instance and a MAX_COUNT=9 instance.
module tb_jk_counter_t_core;

`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        bit         inst;
        string      name;
        logic [3:0] q;
        logic       wrap;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset = 1'b1, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [3:0] a_lval = '0;
    logic [3:0] a_q, a_qbar;
    logic       a_tc, a_wrap;

    logic       b_reset = 1'b1, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
    logic [3:0] b_lval = '0;
    logic [3:0] b_q, b_qbar;
    logic       b_tc, b_wrap;

    jk_counter_t_core #(.WIDTH(4)) a_dut (
        .clk(clk), .reset(a_reset), .en(a_en), .up_dn(a_up), .load(a_load),
        .load_val(a_lval), .q(a_q), .qbar(a_qbar), .tc(a_tc), .wrap(a_wrap)
    );

    jk_counter_t_core #(.WIDTH(4), .MAX_COUNT(9), .RESET_VAL(0)) b_dut (
        .clk(clk), .reset(b_reset), .en(b_en), .up_dn(b_up), .load(b_load),
        .load_val(b_lval), .q(b_q), .qbar(b_qbar), .tc(b_tc), .wrap(b_wrap)
    );

    // Apply one command to one instance (other instance idles) and queue the post-edge expectation.
    task automatic drive(input bit inst, input logic rst, input logic en, input logic up,
                         input logic ld, input logic [3:0] lv, input logic [3:0] eq,
                         input logic ew, input logic etc, input string nm);
        exp_t e;
        @(negedge clk);
        a_reset = 1'b0; a_en = 1'b0; a_load = 1'b0;
        b_reset = 1'b0; b_en = 1'b0; b_load = 1'b0;
        if (!inst) begin
            a_reset = rst; a_en = en; a_up = up; a_load = ld; a_lval = lv;
        end else begin
            b_reset = rst; b_en = en; b_up = up; b_load = ld; b_lval = lv;
        end
        @(posedge clk);
        e.inst = inst; e.name = nm; e.q = eq; e.wrap = ew; e.tc = etc;
        sb.push_back(e);
    endtask

    // Monitor: every edge, retire queued expectations and watch for JK=11 on any cell.
    initial begin
        exp_t       e;
        logic [3:0] gq, gqb;
        logic       gw, gt;
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                gq  = e.inst ? b_q    : a_q;
                gqb = e.inst ? b_qbar : a_qbar;
                gw  = e.inst ? b_wrap : a_wrap;
                gt  = e.inst ? b_tc   : a_tc;
                checks++;
                if (gq !== e.q || gqb !== ~e.q || gw !== e.wrap || gt !== e.tc) begin
                    errors++;
                    $display("FAIL %s inst%0d: got q=%h qbar=%h wrap=%b tc=%b, want q=%h qbar=%h wrap=%b tc=%b",
                             e.name, e.inst, gq, gqb, gw, gt, e.q, ~e.q, e.wrap, e.tc);
                end else begin
                    $display("ok   %s inst%0d: q=%h wrap=%b tc=%b", e.name, e.inst, gq, gw, gt);
                end
            end
            if (!done) begin
                checks++;
                if (((a_dut.w_j & a_dut.w_k) != 4'h0) || ((b_dut.w_j & b_dut.w_k) != 4'h0)) begin
                    errors++;
                    $display("FAIL jk11: got a_jk=%h/%h b_jk=%h/%h, want no bit with J=K=1",
                             a_dut.w_j, a_dut.w_k, b_dut.w_j, b_dut.w_k);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] eq;
        logic       ew, et;

        // Reset state on both instances.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "reset_a");
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, "reset_b");

        // 16 up counts from 0.
        for (int i = 1; i <= 16; i++) begin
            eq = SAT ? ((i > 15) ? 4'd15 : 4'(i)) : 4'(i % 16);
            ew = (i == 16);
            et = (eq == 4'd15);
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, eq, ew, et, "count_up");
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, SAT ? 4'd15 : 4'd1, SAT, SAT, "after_wrap");

        // Load beats enable, then hold.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, "load_en");
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 4'd5, 1'b0, 1'b0, "hold");

        // Reset while q=15 is counting up clears count and pending wrap.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd14, 4'd14, 1'b0, 1'b0, "load14");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd15, 1'b0, 1'b1, "up_to15");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, "reset_mid");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0, 1'b0, "resume");

        // Down wrap on the full-range instance; tc follows up_dn.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, "load0_dn");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, SAT ? 4'd0 : 4'd15, 1'b1, SAT, "down_wrap");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, SAT ? 4'd0 : 4'd14, SAT, SAT, "down_next");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, SAT ? 4'd0 : 4'd14, 1'b0, 1'b0, "hold_updn");

        // Up from 14 for three cycles.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd14, 4'd14, 1'b0, 1'b0, "load14b");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd15, 1'b0, 1'b1, "up14_1");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, SAT ? 4'd15 : 4'd0, 1'b1, SAT, "up14_2");
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, SAT ? 4'd15 : 4'd1, SAT, SAT, "up14_3");

        // MAX_COUNT=9 instance: clamp, wraps in both directions, non-power-of-two top.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 4'd9, 1'b0, 1'b1, "b_clamp");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, SAT ? 4'd9 : 4'd0, 1'b1, SAT, "b_up_wrap");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, "b_load0");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, SAT ? 4'd0 : 4'd9, 1'b1, SAT, "b_dn_wrap");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, SAT ? 4'd0 : 4'd8, SAT, SAT, "b_dn_next");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 4'd8, 1'b0, 1'b0, "b_load8");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd9, 1'b0, 1'b1, "b_up_to9");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 4'd9, 1'b0, 1'b1, "b_clamp10");

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, SAT ? 4'd15 : 4'd1, 1'b0, SAT, "final_hold");
        @(posedge clk);
        #4;
        done = 1'b1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
